// File: rtl/draw_sprite_if.sv
// VGA pixel stream bundle shared by the sprite overlay stage.
// Counters and syncs travel together with the pixel colour.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport source (
    output vcount, hcount, vsync, hsync,
    output vblnk, hblnk, rgb
  );

  modport sink (
    input vcount, hcount, vsync, hsync,
    input vblnk, hblnk, rgb
  );
endinterface

// File: rtl/draw_sprite.sv
// Sprite overlay: windowed ROM lookup merged into a VGA stream.
// Controls are frame-latched at the vblank rise.
module draw_sprite #(
  parameter int          IMG_W      = 64,
  parameter int          IMG_H      = 64,
  parameter int          ROM_LAT    = 1,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [11:0] KEY_RGB    = 12'hF0F,
  localparam int         AW = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          flip_h,
  input  logic [10:0]   xpos,
  input  logic [10:0]   ypos,
  input  logic [11:0]   rgb_pixel,
  output logic [AW-1:0] pixel_addr,
  vga_if.sink           in,
  vga_if.source         out
);

  localparam int L  = ROM_LAT + 1;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [11:0] WIN_W = 12'(IMG_W << SCALE_LOG2);
  localparam logic [11:0] WIN_H = 12'(IMG_H << SCALE_LOG2);

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
    logic        win;
  } stage_t;

  logic        vblnk_prev;
  logic        vblnk_rise;
  logic        enable_s;
  logic        flip_s;
  logic [10:0] xpos_s;
  logic [10:0] ypos_s;

  assign vblnk_rise = in.vblnk & ~vblnk_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_prev <= 1'b0;
      enable_s   <= 1'b0;
      flip_s     <= 1'b0;
      xpos_s     <= '0;
      ypos_s     <= '0;
    end else begin
      vblnk_prev <= in.vblnk;
      if (vblnk_rise) begin
        enable_s <= enable;
        flip_s   <= flip_h;
        xpos_s   <= xpos;
        ypos_s   <= ypos;
      end
    end
  end

  // 12-bit compare keeps xpos_s + W from wrapping
  logic [11:0]      h_ext;
  logic [11:0]      v_ext;
  logic [11:0]      x_ext;
  logic [11:0]      y_ext;
  logic             in_win;
  logic [10:0]      h_off;
  logic [10:0]      v_off;
  logic [XW-1:0]    dx;
  logic [XW-1:0]    col;
  logic [YW-1:0]    dy;
  logic [XW+YW-1:0] addr_full;

  assign h_ext = {1'b0, in.hcount};
  assign v_ext = {1'b0, in.vcount};
  assign x_ext = {1'b0, xpos_s};
  assign y_ext = {1'b0, ypos_s};

  always_comb begin
    in_win = (h_ext >= x_ext)
          && (h_ext < x_ext + WIN_W)
          && (v_ext >= y_ext)
          && (v_ext < y_ext + WIN_H);
    h_off = in.hcount - xpos_s;
    v_off = in.vcount - ypos_s;
    dx = XW'(h_off >> SCALE_LOG2);
    dy = YW'(v_off >> SCALE_LOG2);
    // IMG_W is a power of two, so IMG_W-1-dx is ~dx
    col = flip_s ? ~dx : dx;
    addr_full = {dy, col};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_addr <= '0;
    end else if (in_win) begin
      pixel_addr <= addr_full[AW-1:0];
    end
  end

  stage_t head;
  stage_t pipe [L];
  stage_t tail;

  assign head = {in.vcount, in.hcount, in.vsync, in.hsync,
                 in.vblnk, in.hblnk, in.rgb, in_win};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < L; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= head;
      for (int i = 1; i < L; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail = pipe[L-1];

  logic draw;

  assign draw = tail.win && enable_s
             && !tail.hblnk && !tail.vblnk
             && (rgb_pixel != KEY_RGB);

  assign out.vcount = tail.vcount;
  assign out.hcount = tail.hcount;
  assign out.vsync  = tail.vsync;
  assign out.hsync  = tail.hsync;
  assign out.vblnk  = tail.vblnk;
  assign out.hblnk  = tail.hblnk;
  assign out.rgb    = draw ? rgb_pixel : tail.rgb;

endmodule

// File: doc/draw_sprite.md
DRAW_SPRITE -- requirements
Module: draw_sprite

Interface
REQ-001 SHALL have parameter IMG_W, default 64, sprite width in pixels (power of two, 2..512).
REQ-002 SHALL have parameter IMG_H, default 64, sprite height in pixels (1..512).
REQ-003 SHALL have parameter ROM_LAT, default 1, image ROM read latency in clock cycles (1..4).
REQ-004 SHALL have parameter SCALE_LOG2, default 0, integer upscale exponent; each sprite pixel covers a 2^SCALE_LOG2 square (0..2).
REQ-005 SHALL have parameter KEY_RGB, default 12'hF0F, transparent colour.
REQ-006 SHALL have port clk, input, 1, pixel clock (40 MHz).
REQ-007 SHALL have port rst, input, 1, reset; one clock, asynchronous, active-low.
REQ-008 SHALL have port enable, input, 1, sprite visible when high.
REQ-009 SHALL have port flip_h, input, 1, mirror the sprite horizontally.
REQ-010 SHALL have port xpos, input, 11, sprite left edge in hcount units.
REQ-011 SHALL have port ypos, input, 11, sprite top edge in vcount units.
REQ-012 SHALL have port rgb_pixel, input, 12, ROM data, valid ROM_LAT cycles after pixel_addr.
REQ-013 SHALL have port pixel_addr, output, $clog2(IMG_W*IMG_H), ROM address.
REQ-014 SHALL have port in, vga_if input, VGA stream: vcount/hcount 11, vsync/hsync/vblnk/hblnk 1, rgb 12.
REQ-015 SHALL have port out, vga_if output, same fields as in.

Function
REQ-016 SHALL sample enable, flip_h, xpos and ypos into shadow registers only on the cycle where in.vblnk goes 0->1, so that nothing changes mid-frame.
REQ-017 SHALL set the window size to W = IMG_W<<SCALE_LOG2 and H = IMG_H<<SCALE_LOG2.
REQ-018 SHALL use pixel (h,v) as in-window iff xpos_s <= h < xpos_s+W and ypos_s <= v < ypos_s+H.
REQ-019 SHALL compare in 12-bit unsigned arithmetic so that xpos_s+W never wraps.
REQ-020 SHALL compute dx=(h-xpos_s)>>SCALE_LOG2 and dy=(v-ypos_s)>>SCALE_LOG2.
REQ-021 SHALL register pixel_addr = dy*IMG_W + (flip_s ? IMG_W-1-dx : dx) one cycle after the input pixel.
REQ-022 SHALL hold pixel_addr at its last value when the pixel is out of window.
REQ-023 SHALL delay vcount, hcount, vsync, hsync, vblnk, hblnk, rgb and the in-window flag through a shift pipeline of L = ROM_LAT+1 stages.
REQ-024 SHALL have a total input-to-out latency of exactly L cycles for every field.
REQ-025 SHALL drive out.rgb = rgb_pixel when the delayed in-window flag is 1, enable_s = 1, the delayed hblnk = 0, the delayed vblnk = 0 and rgb_pixel != KEY_RGB; otherwise out.rgb = delayed in.rgb.
REQ-026 SHALL pass all out timing fields unmodified, only delayed.
REQ-027 SHALL require in.vblnk to rise between frames for new shadow values to appear; the first frame after reset uses reset shadow values, so the sprite is hidden.
REQ-028 SHALL draw a sprite partially beyond the visible area only in its visible part; the blanking rule of REQ-025 suppresses the rest.
REQ-029 SHALL have the shadow-latch path take effect at the next vblnk rise, and the new frame start SHALL use the shadow values sampled at that same edge.

Reset
REQ-030 SHALL, while rst=0, force immediately all out fields, pixel_addr, all pipeline stages and shadow registers to 0, enable_s=0 and flip_s=0.
REQ-031 SHALL, on rst release mid-line, begin producing valid out data L cycles after the first input sample.
REQ-032 SHALL keep the sprite hidden until the first vblnk rise after reset.

Verification
REQ-033 SHALL be verified by: defaults, xpos=100, ypos=50, enable=1, ROM returns address[11:0] -> at out hcount=100/vcount=50 rgb=0x000; at hcount=163 rgb=0x03F; at hcount=164 rgb = in.rgb passthrough; latency 2 cycles.
REQ-034 SHALL be verified by: flip_h=1, same setup -> out hcount=100 shows address 63; hcount=163 shows address 0.
REQ-035 SHALL be verified by: SCALE_LOG2=1 -> pixels hcount 100 and 101 both use address 0, the window ends at hcount 227, and the second row is at vcount 52.
REQ-036 SHALL be verified by: ROM returns 0xF0F inside the window -> out.rgb equals delayed in.rgb; with enable=0 the same window passes through completely.
REQ-037 SHALL be verified by: xpos changed from 100 to 300 at vcount=200 -> the rest of the frame is drawn at 100 and the next frame at 300.
REQ-038 SHALL be verified by: rst pulled low mid-window -> out and pixel_addr are 0 in the same cycle; after release the sprite stays hidden until the next vblnk rise.
